// File: rtl/sc_io_mailbox.sv
// SCOMP IO-bus mailbox: 4-register window bridging SCOMP to a TX and an RX 16-bit FIFO.
// Optional interrupt logic (o_irq, CTRL[1:0], STATUS[4]) is built only with SC_MBOX_IRQ_EN.
module sc_io_mailbox #(
  parameter logic [7:0] BASE_ADDR  = 8'h40,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_sc_iocyc,
  input  logic        i_sc_iowr,
  input  logic [7:0]  i_sc_ioaddr,
  inout  wire  [15:0] io_sc_iodata,
  output logic [15:0] o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  input  logic [15:0] i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic        o_irq
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic        iocyc_q, drive_q;
  logic [15:0] rd_hold, rd_val, wdata;
  logic        start, hit, wr_cyc, rd_cyc;
  logic [1:0]  off;

  // iocyc_q resets high so a cycle already in flight across reset never starts.
  assign start  = i_sc_iocyc && !iocyc_q;
  assign hit    = (i_sc_ioaddr[7:2] == BASE_ADDR[7:2]);
  assign off    = i_sc_ioaddr[1:0];
  assign wr_cyc = start && hit && i_sc_iowr;
  assign rd_cyc = start && hit && !i_sc_iowr;
  assign wdata  = io_sc_iodata;

  assign io_sc_iodata = (drive_q && i_sc_iocyc) ? rd_hold : 16'hzzzz;

  // TX FIFO: SCOMP pushes, host pops
  logic [15:0]   tx_mem [DEPTH];
  logic [PW-1:0] tx_wptr, tx_rptr, tx_cnt;
  logic          tx_full, tx_empty, tx_push, tx_pop, tx_drop, flush_tx;

  assign tx_cnt   = tx_wptr - tx_rptr;
  assign tx_full  = (tx_cnt == PW'(DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign tx_push  = wr_cyc && (off == 2'd0) && !tx_full;
  assign tx_drop  = wr_cyc && (off == 2'd0) && tx_full;
  assign tx_pop   = !tx_empty && i_tx_ready;
  assign flush_tx = wr_cyc && (off == 2'd2) && wdata[8];

  assign o_tx_valid = !tx_empty;
  assign o_tx_data  = tx_mem[tx_rptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else if (flush_tx) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk)
    if (tx_push) tx_mem[tx_wptr[DEPTH_LOG2-1:0]] <= wdata;

  // RX FIFO: host pushes, SCOMP pops
  logic [15:0]   rx_mem [DEPTH];
  logic [PW-1:0] rx_wptr, rx_rptr, rx_cnt;
  logic          rx_full, rx_empty, rx_push, rx_pop, rx_unf_set, flush_rx;

  assign rx_cnt     = rx_wptr - rx_rptr;
  assign rx_full    = (rx_cnt == PW'(DEPTH));
  assign rx_empty   = (rx_cnt == '0);
  assign o_rx_ready = !i_reset && !rx_full;
  assign rx_push    = i_rx_valid && o_rx_ready;
  assign rx_pop     = rd_cyc && (off == 2'd0) && !rx_empty;
  assign rx_unf_set = rd_cyc && (off == 2'd0) && rx_empty;
  assign flush_rx   = wr_cyc && (off == 2'd2) && wdata[9];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else if (flush_rx) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk)
    if (rx_push) rx_mem[rx_wptr[DEPTH_LOG2-1:0]] <= i_rx_data;

  // sticky error flags
  logic tx_ovf, rx_unf, clr_flags;
  assign clr_flags = wr_cyc && (off == 2'd2) && wdata[10];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else if (clr_flags) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      if (tx_drop)    tx_ovf <= 1'b1;
      if (rx_unf_set) rx_unf <= 1'b1;
    end
  end

  logic irq_en_rx, irq_en_tx;
`ifdef SC_MBOX_IRQ_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      irq_en_rx <= 1'b0;
      irq_en_tx <= 1'b0;
      o_irq     <= 1'b0;
    end else begin
      if (wr_cyc && (off == 2'd2)) begin
        irq_en_rx <= wdata[0];
        irq_en_tx <= wdata[1];
      end
      o_irq <= (irq_en_rx && !rx_empty) || (irq_en_tx && tx_empty);
    end
  end
  logic unused_bits;
  assign unused_bits = ^{wdata[15:11], wdata[7:2]};
`else
  assign irq_en_rx = 1'b0;
  assign irq_en_tx = 1'b0;
  assign o_irq     = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{wdata[15:11], wdata[7:0]};
`endif

  always_comb begin
    rd_val = 16'h0000;
    case (off)
      2'd0: rd_val = rx_empty ? 16'h0000 : rx_mem[rx_rptr[DEPTH_LOG2-1:0]];
      2'd1: rd_val = {8'(rx_cnt), 3'b000, o_irq, rx_unf, tx_ovf, tx_full, !rx_empty};
      2'd2: rd_val = {14'h0000, irq_en_tx, irq_en_rx};
      default: rd_val = 16'h0000;
    endcase
  end

  // read data is captured before the pop so the driven word stays stable
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      iocyc_q <= 1'b1;
      drive_q <= 1'b0;
      rd_hold <= 16'h0000;
    end else begin
      iocyc_q <= i_sc_iocyc;
      if (!i_sc_iocyc)  drive_q <= 1'b0;
      else if (rd_cyc)  drive_q <= 1'b1;
      if (rd_cyc) rd_hold <= rd_val;
    end
  end
endmodule

// File: tb/tb_sc_io_mailbox.sv
// Self-checking bench for sc_io_mailbox: SCOMP op table, TX scoreboard, multi-cycle corner sequences.
module tb_sc_io_mailbox;
  logic        clk = 1'b0;
  logic        rst;
  logic        iocyc, iowr;
  logic [7:0]  ioaddr;
  logic [15:0] dout;
  logic        drv;
  wire  [15:0] io_sc_iodata;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid, rx_ready, irq;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb [$];

`ifdef SC_MBOX_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif
  localparam logic [15:0] CTRL3 = IRQ_ON ? 16'h0003 : 16'h0000;

  // undriven bus reads back as all ones
  pullup (io_sc_iodata);
  assign io_sc_iodata = drv ? dout : 16'hzzzz;

  sc_io_mailbox #(.BASE_ADDR(8'h40), .DEPTH_LOG2(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_sc_iocyc(iocyc), .i_sc_iowr(iowr),
    .i_sc_ioaddr(ioaddr), .io_sc_iodata(io_sc_iodata),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
    .o_irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // handshake monitor compares delivered TX words against the scoreboard
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected got %h exp none", tx_data);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        if (tx_data !== e) begin
          errors++;
          $display("FAIL tx_word got %h exp %h", tx_data, e);
        end
      end
    end
  end

  // all tasks enter and leave 1 time unit after a rising edge
  task automatic sc_write(input logic [7:0] a, input logic [15:0] d);
    iocyc = 1'b1; iowr = 1'b1; ioaddr = a; dout = d; drv = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    iocyc = 1'b0; drv = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic sc_read(input logic [7:0] a, output logic [15:0] d);
    iocyc = 1'b1; iowr = 1'b0; ioaddr = a;
    @(posedge clk); #1;
    d = io_sc_iodata;
    @(posedge clk); #1;
    iocyc = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic push_rx(input logic [15:0] d);
    rx_valid = 1'b1; rx_data = d;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic drain_tx();
    tx_ready = 1'b1;
    for (int i = 0; i < 64 && sb.size() > 0; i++) @(posedge clk);
    #1 tx_ready = 1'b0;
    chk("drain_sb_empty", 16'(sb.size()), 16'd0);
    chk("drain_tx_valid", {15'd0, tx_valid}, 16'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vt [16];

  initial begin
    logic [15:0] r;
    rst = 1'b1; iocyc = 1'b0; iowr = 1'b0; ioaddr = 8'h00; dout = 16'h0; drv = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 16'h0;

    vt[0]  = '{1'b0, 8'h41, 16'h0000, 16'h0201, "st_two"};
    vt[1]  = '{1'b0, 8'h40, 16'h0000, 16'h1234, "pop_1"};
    vt[2]  = '{1'b0, 8'h40, 16'h0000, 16'h5678, "pop_2"};
    vt[3]  = '{1'b0, 8'h40, 16'h0000, 16'h0000, "pop_empty"};
    vt[4]  = '{1'b0, 8'h41, 16'h0000, 16'h0008, "st_unf"};
    vt[5]  = '{1'b1, 8'h41, 16'hFFFF, 16'h0000, ""};
    vt[6]  = '{1'b0, 8'h41, 16'h0000, 16'h0008, "st_ro"};
    vt[7]  = '{1'b1, 8'h43, 16'hFFFF, 16'h0000, ""};
    vt[8]  = '{1'b0, 8'h43, 16'h0000, 16'h0000, "reg3"};
    vt[9]  = '{1'b1, 8'h42, 16'h0003, 16'h0000, ""};
    vt[10] = '{1'b0, 8'h42, 16'h0000, CTRL3,    "ctrl"};
    vt[11] = '{1'b1, 8'h42, 16'h0400, 16'h0000, ""};
    vt[12] = '{1'b0, 8'h41, 16'h0000, 16'h0000, "st_clr"};
    vt[13] = '{1'b1, 8'h44, 16'h0040, 16'h0000, ""};
    vt[14] = '{1'b0, 8'h3C, 16'h0000, 16'hFFFF, "nohit_3c"};
    vt[15] = '{1'b0, 8'h80, 16'h0000, 16'hFFFF, "nohit_80"};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready", {15'd0, rx_ready}, 16'd0);
    chk("rst_tx_valid", {15'd0, tx_valid}, 16'd0);
    chk("rst_irq", {15'd0, irq}, 16'd0);
    chk("rst_bus", io_sc_iodata, 16'hFFFF);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rx_ready", {15'd0, rx_ready}, 16'd1);
    sc_read(8'h41, r); chk("post_rst_status", r, 16'h0000);

    // basic TX
    sc_write(8'h40, 16'hBEEF); sb.push_back(16'hBEEF);
    chk("tx_valid", {15'd0, tx_valid}, 16'd1);
    chk("tx_head", tx_data, 16'hBEEF);
    tx_ready = 1'b1; @(posedge clk); #1; tx_ready = 1'b0;
    chk("tx_valid_after", {15'd0, tx_valid}, 16'd0);

    // register table
    push_rx(16'h1234); push_rx(16'h5678);
    for (int i = 0; i < 16; i++) begin
      if (vt[i].wr) sc_write(vt[i].addr, vt[i].data);
      else begin
        sc_read(vt[i].addr, r);
        chk(vt[i].name, r, vt[i].exp);
      end
    end
    chk("nohit_no_push", {15'd0, tx_valid}, 16'd0);

    // TX overflow, drain order and wrap-around
    for (int i = 0; i < 17; i++) begin
      sc_write(8'h40, 16'(i));
      if (i < 16) sb.push_back(16'(i));
    end
    sc_read(8'h41, r); chk("st_tx_full_ovf", r, 16'h0006);
    drain_tx();
    sc_write(8'h42, 16'h0400);
    sc_read(8'h41, r); chk("st_ovf_clr", r, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      sc_write(8'h40, 16'hA000 + 16'(i)); sb.push_back(16'hA000 + 16'(i));
    end
    drain_tx();

    // interrupt on RX non-empty
    sc_write(8'h42, 16'h0001);
    rx_valid = 1'b1; rx_data = 16'hC0DE;
    @(posedge clk); #1; rx_valid = 1'b0;
    chk("irq_same", {15'd0, irq}, 16'd0);
    @(posedge clk); #1;
    chk("irq_next", {15'd0, irq}, {15'd0, IRQ_ON});
    sc_read(8'h40, r); chk("irq_pop", r, 16'hC0DE);
    chk("irq_clear", {15'd0, irq}, 16'd0);
    sc_write(8'h42, 16'h0000);

    // RX full then flush; then flush coincident with a push
    for (int i = 0; i < 16; i++) push_rx(16'h5000 + 16'(i));
    chk("rx_full_ready", {15'd0, rx_ready}, 16'd0);
    sc_read(8'h41, r); chk("st_rx_full", r, 16'h1001);
    sc_write(8'h42, 16'h0200);
    sc_read(8'h41, r); chk("st_rx_flush", r, 16'h0000);
    for (int i = 0; i < 15; i++) push_rx(16'h6000 + 16'(i));
    rx_valid = 1'b1; rx_data = 16'h6FFF;
    iocyc = 1'b1; iowr = 1'b1; ioaddr = 8'h42; dout = 16'h0200; drv = 1'b1;
    @(posedge clk); #1; rx_valid = 1'b0;
    @(posedge clk); #1; iocyc = 1'b0; drv = 1'b0;
    @(posedge clk); #1;
    chk("flush_push_ready", {15'd0, rx_ready}, 16'd1);
    sc_read(8'h41, r); chk("flush_push_status", r, 16'h0000);

    // TX flush coincident with a handshake: head delivered, rest discarded
    sc_write(8'h40, 16'hA1A1); sb.push_back(16'hA1A1);
    sc_write(8'h40, 16'hA2A2); sb.push_back(16'hA2A2);
    tx_ready = 1'b1;
    iocyc = 1'b1; iowr = 1'b1; ioaddr = 8'h42; dout = 16'h0100; drv = 1'b1;
    @(posedge clk); #1; tx_ready = 1'b0;
    chk("txflush_sb", 16'(sb.size()), 16'd1);
    sb.delete();
    chk("txflush_valid", {15'd0, tx_valid}, 16'd0);
    @(posedge clk); #1; iocyc = 1'b0; drv = 1'b0;
    @(posedge clk); #1;

    // reset in the middle of a held read cycle
    push_rx(16'h0011); push_rx(16'h0022);
    iocyc = 1'b1; iowr = 1'b0; ioaddr = 8'h41;
    @(posedge clk); #1;
    chk("mid_read_data", io_sc_iodata, 16'h0201);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_bus", io_sc_iodata, 16'hFFFF);
    ioaddr = 8'h40; rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("held_no_drive", io_sc_iodata, 16'hFFFF);
    iocyc = 1'b0;
    @(posedge clk); #1;
    sc_read(8'h41, r); chk("held_no_effect", r, 16'h0000);
    push_rx(16'h0077);
    sc_read(8'h41, r); chk("after_rst_status", r, 16'h0101);
    sc_read(8'h40, r); chk("after_rst_pop", r, 16'h0077);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
